// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Classifies gestures on a debounced push-button level as SINGLE, DOUBLE or
//   LONG press and reports each one to the UART command/status logic.
//   All logic runs on the rising edge of slow_clk.
//
// Parameters
//   LONG_TICKS  high samples (including the rise sample) that make a LONG press, 2..255
//   GAP_TICKS   low samples (including the fall sample) that close a SINGLE press, 1..255
//
// Ports
//   slow_clk    in   1  divided clock
//   rst         in   1  asynchronous, active-high reset
//   pb_in       in   1  debounced button level, 1 = pressed
//   single_evt  out  1  one-cycle strobe: single press recognised
//   double_evt  out  1  one-cycle strobe: double press recognised
//   long_evt    out  1  one-cycle strobe: long press recognised
//   evt_code    out  2  last event, held: 00 none, 01 single, 10 double, 11 long
//   evt_count   out  8  events since reset, wraps 255 -> 0
//   busy        out  1  high while a gesture is in progress
module button_event_decoder #(
    parameter int unsigned LONG_TICKS = 40,
    parameter int unsigned GAP_TICKS  = 10
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic       pb_in,
    output logic       single_evt,
    output logic       double_evt,
    output logic       long_evt,
    output logic [1:0] evt_code,
    output logic [7:0] evt_count,
    output logic       busy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

    localparam logic [1:0] CODE_SINGLE = 2'b01;
    localparam logic [1:0] CODE_DOUBLE = 2'b10;
    localparam logic [1:0] CODE_LONG   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             pb_q;
    logic             rise_c;
    logic             fall_c;
    logic             single_c;
    logic             double_c;
    logic             long_c;
    logic             any_evt_c;
    logic [1:0]       code_c;

    // pb_q resets to 1 so a button held through reset needs a fresh press.
    assign rise_c    = pb_in & ~pb_q;
    assign fall_c    = ~pb_in & pb_q;
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // State register and edge-detect history.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pb_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pb_q    <= pb_in;
        end
    end

    // Next-state and sample counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d = PRESS1;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS1: begin
                if (pb_in) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end else if (GAP_TICKS == 1) begin
                    // The fall sample alone already closes the gap.
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(1);
                end
            end
            GAP: begin
                if (rise_c) begin
                    state_d = PRESS2;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            PRESS2: begin
                if (fall_c) begin
                    state_d = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    // A long second press is still reported as DOUBLE.
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            HOLD: begin
                if (fall_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Event decisions derived from the transition being taken this cycle.
    always_comb begin
        single_c = 1'b0;
        double_c = 1'b0;
        long_c   = 1'b0;
        code_c   = CODE_SINGLE;
        case (state_q)
            PRESS1: begin
                long_c   = (state_d == HOLD);
                single_c = (state_d == IDLE);
            end
            GAP: begin
                single_c = (state_d == IDLE);
            end
            PRESS2: begin
                double_c = (state_d == IDLE) || (state_d == HOLD);
            end
            default: begin
                single_c = 1'b0;
            end
        endcase
        any_evt_c = single_c | double_c | long_c;
        if (long_c) begin
            code_c = CODE_LONG;
        end else if (double_c) begin
            code_c = CODE_DOUBLE;
        end
    end

    // Registered outputs.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            single_evt <= 1'b0;
            double_evt <= 1'b0;
            long_evt   <= 1'b0;
            evt_code   <= 2'b00;
            evt_count  <= '0;
            busy       <= 1'b0;
        end else begin
            single_evt <= single_c;
            double_evt <= double_c;
            long_evt   <= long_c;
            busy       <= (state_d != IDLE);
            if (any_evt_c) begin
                evt_code  <= code_c;
                evt_count <= evt_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder (LONG_TICKS=8, GAP_TICKS=4).
// A run-length model classifies the sampled button level; every cycle the
// DUT outputs are compared to it, and directed scenarios add literal checks.
module tb_button_event_decoder;

    localparam int unsigned LONG_T = 8;
    localparam int unsigned GAP_T  = 4;

    logic       slow_clk;
    logic       rst;
    logic       pb_in;
    logic       single_evt;
    logic       double_evt;
    logic       long_evt;
    logic [1:0] evt_code;
    logic [7:0] evt_count;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    button_event_decoder #(
        .LONG_TICKS(LONG_T),
        .GAP_TICKS (GAP_T)
    ) dut (
        .slow_clk  (slow_clk),
        .rst       (rst),
        .pb_in     (pb_in),
        .single_evt(single_evt),
        .double_evt(double_evt),
        .long_evt  (long_evt),
        .evt_code  (evt_code),
        .evt_count (evt_count),
        .busy      (busy)
    );

    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- model ----------------
    // runs holds alternating run lengths of the current gesture: high, low, high, low.
    int         runs[$];
    bit         m_held = 1'b0;
    bit         m_prev = 1'b1;
    bit         exp_single = 1'b0;
    bit         exp_double = 1'b0;
    bit         exp_long   = 1'b0;
    logic [1:0] exp_code   = 2'b00;
    logic [7:0] exp_count  = 8'd0;
    bit         exp_busy   = 1'b0;

    task automatic model_reset();
        runs.delete();
        m_held     = 1'b0;
        m_prev     = 1'b1;
        exp_single = 1'b0;
        exp_double = 1'b0;
        exp_long   = 1'b0;
        exp_code   = 2'b00;
        exp_count  = 8'd0;
        exp_busy   = 1'b0;
    endtask

    task automatic model_step(input bit s);
        int last;
        bit cur_high;
        exp_single = 1'b0;
        exp_double = 1'b0;
        exp_long   = 1'b0;
        if (m_held) begin
            if (!s) m_held = 1'b0;
        end else if (runs.size() == 0) begin
            if (s && !m_prev) runs.push_back(1);
        end else begin
            last     = runs.size() - 1;
            cur_high = (runs.size() % 2) == 1;
            if (s == cur_high) runs[last] = runs[last] + 1;
            else runs.push_back(1);
            case (runs.size())
                1: if (runs[0] == LONG_T) begin exp_long = 1'b1; m_held = 1'b1; runs.delete(); end
                2: if (runs[1] == GAP_T) begin exp_single = 1'b1; runs.delete(); end
                3: if (runs[2] == LONG_T) begin exp_double = 1'b1; m_held = 1'b1; runs.delete(); end
                4: begin exp_double = 1'b1; runs.delete(); end
                default: ;
            endcase
        end
        if (exp_single) exp_code = 2'b01;
        if (exp_double) exp_code = 2'b10;
        if (exp_long)   exp_code = 2'b11;
        if (exp_single || exp_double || exp_long) exp_count = exp_count + 8'd1;
        exp_busy = (runs.size() != 0) || m_held;
        m_prev   = s;
    endtask

    // Per-cycle compare against the model.
    always @(posedge slow_clk) begin
        if (rst) model_reset();
        else model_step(pb_in);
        #1;
        chk("single_evt", int'(single_evt), int'(exp_single));
        chk("double_evt", int'(double_evt), int'(exp_double));
        chk("long_evt",   int'(long_evt),   int'(exp_long));
        chk("evt_code",   int'(evt_code),   int'(exp_code));
        chk("evt_count",  int'(evt_count),  int'(exp_count));
        chk("busy",       int'(busy),       int'(exp_busy));
        chk("one_strobe", int'($countones({single_evt, double_evt, long_evt}) <= 1), 1);
    end

    // Drive one sample; return just after the edge that captured it.
    task automatic step(input logic v);
        pb_in = v;
        @(posedge slow_clk);
        #2;
    endtask

    task automatic steps(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin
        rst   = 1'b1;
        pb_in = 1'b0;
        steps(1'b0, 3);
        rst = 1'b0;
        step(1'b0);

        // 1: reset state, then a button held through reset
        chk("rst_strobes", int'({single_evt, double_evt, long_evt}), 0);
        chk("rst_code",    int'(evt_code), 0);
        chk("rst_count",   int'(evt_count), 0);
        chk("rst_busy",    int'(busy), 0);
        pb_in = 1'b1;
        rst   = 1'b1;
        steps(1'b1, 2);
        rst = 1'b0;
        steps(1'b1, 5);
        chk("held_busy",  int'(busy), 0);
        chk("held_count", int'(evt_count), 0);
        step(1'b0);
        step(1'b1);
        chk("fresh_rise_busy", int'(busy), 1);
        rst = 1'b1;
        steps(1'b0, 2);
        rst = 1'b0;
        step(1'b0);

        // 2: single press
        steps(1'b1, 3);
        steps(1'b0, 3);
        chk("single_early", int'(single_evt), 0);
        step(1'b0);
        chk("single_fire",  int'(single_evt), 1);
        chk("single_code",  int'(evt_code), 1);
        chk("single_count", int'(evt_count), 1);

        // 3: double press, starting on the strobe cycle
        steps(1'b1, 3);
        steps(1'b0, 2);
        steps(1'b1, 2);
        step(1'b0);
        chk("double_fire",  int'(double_evt), 1);
        chk("double_code",  int'(evt_code), 2);
        chk("double_count", int'(evt_count), 2);
        step(1'b0);
        chk("double_busy",  int'(busy), 0);

        // 4: long press
        steps(1'b1, 7);
        chk("long_early", int'(long_evt), 0);
        step(1'b1);
        chk("long_fire",  int'(long_evt), 1);
        chk("long_code",  int'(evt_code), 3);
        chk("long_count", int'(evt_count), 3);
        steps(1'b1, 12);
        chk("long_hold_busy",  int'(busy), 1);
        chk("long_hold_count", int'(evt_count), 3);
        step(1'b0);
        chk("long_release_busy", int'(busy), 0);

        // 5: reset during the gap discards the gesture
        steps(1'b1, 2);
        steps(1'b0, 2);
        rst = 1'b1;
        #1;
        chk("midrst_count", int'(evt_count), 0);
        chk("midrst_busy",  int'(busy), 0);
        steps(1'b0, 2);
        rst = 1'b0;
        steps(1'b0, 6);
        chk("midrst_after_count", int'(evt_count), 0);
        chk("midrst_after_code",  int'(evt_code), 0);

        // 6: 256 back-to-back single presses wrap the counter
        for (int p = 0; p < 256; p++) begin
            step(1'b1);
            steps(1'b0, 4);
            if (p == 254) chk("wrap_255", int'(evt_count), 255);
        end
        chk("wrap_count", int'(evt_count), 0);
        chk("wrap_code",  int'(evt_code), 1);
        steps(1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
